// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the control sequencer: opcodes, FSM states, IR field positions.
// Pure definitions; no latency, no flow control.
package control_sequencer_pkg;

  localparam int BITS_DEFAULT      = 32;
  localparam int REGISTERS_DEFAULT = 16;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int RA_MSB     = 26;
  localparam int RA_LSB     = 23;
  localparam int RB_MSB     = 22;
  localparam int RB_LSB     = 19;
  localparam int RC_MSB     = 18;
  localparam int RC_LSB     = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALU3, CLS_MULDIV, CLS_UNARY, CLS_HALT
  } op_class_t;

  // Field order mirrors IR[31:15], so a slice of the IR casts straight into it.
  typedef struct packed {
    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
  } ir_fields_t;

endpackage

// File: rtl/control_sequencer_ir_decode.sv
// Combinational IR decode: opcode class plus one-hot ra/rb/rc register selects.
// Zero latency; no flow control.
module ir_decode
  import control_sequencer_pkg::*;
#(
  parameter int REGISTERS = REGISTERS_DEFAULT
) (
  input  ir_fields_t               fields,
  output op_class_t                op_class,
  output logic [REGISTERS-1:0]     ra_sel,
  output logic [REGISTERS-1:0]     rb_sel,
  output logic [REGISTERS-1:0]     rc_sel
);

  localparam logic [REGISTERS-1:0] ONE = REGISTERS'(1);

  always_comb begin
    op_class = CLS_NOP;
    case (fields.opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:  op_class = CLS_ALU3;
      OP_MUL, OP_DIV:                 op_class = CLS_MULDIV;
      OP_NEG, OP_NOT:                 op_class = CLS_UNARY;
      OP_HALT:                        op_class = CLS_HALT;
      default:                        op_class = CLS_NOP;
    endcase
  end

  assign ra_sel = ONE << fields.ra;
  assign rb_sel = ONE << fields.rb;
  assign rc_sel = ONE << fields.rc;

endmodule

// File: rtl/control_sequencer.sv
// Moore control FSM sequencing fetch/execute strobes; 4-7 cycles per instruction.
// Stop pauses only at instruction boundaries; HALT parks until reset.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int BITS      = BITS_DEFAULT,
  parameter int REGISTERS = REGISTERS_DEFAULT
) (
  input  logic                 Clock,
  input  logic                 reset,
  input  logic [BITS-1:0]      IRVal,
  input  logic                 Stop,
  output logic                 PCout,
  output logic                 PCin,
  output logic                 IncPC,
  output logic                 MARin,
  output logic                 Read,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 RYin,
  output logic                 RZin,
  output logic                 Zlowout,
  output logic                 Zhighout,
  output logic                 HIin,
  output logic                 LOin,
  output logic                 ADD,
  output logic                 SUB,
  output logic                 MUL,
  output logic                 DIV,
  output logic                 SHR,
  output logic                 SHL,
  output logic                 ROR,
  output logic                 ROL,
  output logic                 AND,
  output logic                 OR,
  output logic                 NEGATE,
  output logic                 NOT,
  output logic                 Run,
  output logic [REGISTERS-1:0] GPRin,
  output logic [REGISTERS-1:0] GPRout
);

  state_t                 state, state_nxt;
  ir_fields_t             ir_q;
  op_class_t              op_class;
  logic [REGISTERS-1:0]   ra_sel, rb_sel, rc_sel;
  logic                   op_en;
  logic                   done;
  logic                   unused_ir_bits;

  assign unused_ir_bits = ^IRVal[RC_LSB-1:0];

  // Fields are captured as IR is loaded, so execute states see a stable word.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ir_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_T2)
        ir_q <= ir_fields_t'(IRVal[OPCODE_MSB:RC_LSB]);
    end
  end

  ir_decode #(.REGISTERS(REGISTERS)) u_ir_decode (
    .fields   (ir_q),
    .op_class (op_class),
    .ra_sel   (ra_sel),
    .rb_sel   (rb_sel),
    .rc_sel   (rc_sel)
  );

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    op_en     = 1'b0;
    {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, RYin, RZin,
     Zlowout, Zhighout, HIin, LOin} = '0;
    {ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT} = '0;
    GPRin  = '0;
    GPRout = '0;

    case (state)
      S_IDLE: if (!Stop) state_nxt = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_nxt = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_nxt = S_T3;
      end
      S_T3: begin
        case (op_class)
          CLS_ALU3:   begin GPRout = rb_sel; RYin = 1'b1; state_nxt = S_T4; end
          CLS_MULDIV: begin GPRout = ra_sel; RYin = 1'b1; state_nxt = S_T4; end
          CLS_UNARY:  begin GPRout = rb_sel; op_en = 1'b1; RZin = 1'b1; state_nxt = S_T4; end
          CLS_HALT:   state_nxt = S_HALTED;
          default:    done = 1'b1;
        endcase
      end
      S_T4: begin
        case (op_class)
          CLS_ALU3, CLS_MULDIV: begin
            GPRout = (op_class == CLS_ALU3) ? rc_sel : rb_sel;
            op_en  = 1'b1;
            RZin   = 1'b1;
            state_nxt = S_T5;
          end
          CLS_UNARY: begin Zlowout = 1'b1; GPRin = ra_sel; done = 1'b1; end
          default:   done = 1'b1;
        endcase
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (op_class == CLS_MULDIV) begin
          LOin = 1'b1;
          state_nxt = S_T6;
        end else begin
          GPRin = ra_sel;
          done  = 1'b1;
        end
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1;
        done = 1'b1;
      end
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase

    if (done)
      state_nxt = Stop ? S_IDLE : S_T0;

    if (op_en) begin
      case (ir_q.opcode)
        OP_ADD:  ADD    = 1'b1;
        OP_SUB:  SUB    = 1'b1;
        OP_SHR:  SHR    = 1'b1;
        OP_SHL:  SHL    = 1'b1;
        OP_ROR:  ROR    = 1'b1;
        OP_ROL:  ROL    = 1'b1;
        OP_AND:  AND    = 1'b1;
        OP_OR:   OR     = 1'b1;
        OP_MUL:  MUL    = 1'b1;
        OP_DIV:  DIV    = 1'b1;
        OP_NEG:  NEGATE = 1'b1;
        OP_NOT:  NOT    = 1'b1;
        default: ;
      endcase
    end

    Run = (state != S_IDLE) && (state != S_HALTED);
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle vector table plus reset/halt sequences.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        reset;
  logic [31:0] IRVal;
  logic        Stop;
  logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, RYin, RZin;
  logic Zlowout, Zhighout, HIin, LOin, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL;
  logic AND, OR, NEGATE, NOT, Run;
  logic [15:0] GPRin, GPRout;
  logic [26:0] sig;

  int n_assert = 0;
  int n_fail   = 0;

  control_sequencer dut (
    .Clock(Clock), .reset(reset), .IRVal(IRVal), .Stop(Stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .RYin(RYin), .RZin(RZin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL),
    .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR), .NEGATE(NEGATE), .NOT(NOT),
    .Run(Run), .GPRin(GPRin), .GPRout(GPRout)
  );

  always #5 Clock = ~Clock;

  assign sig = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, RYin, RZin,
                Zlowout, Zhighout, HIin, LOin, ADD, SUB, MUL, DIV, SHR, SHL,
                ROR, ROL, AND, OR, NEGATE, NOT, Run};

  localparam logic [26:0] B_PCOUT  = 27'(1) << 26;
  localparam logic [26:0] B_PCIN   = 27'(1) << 25;
  localparam logic [26:0] B_INCPC  = 27'(1) << 24;
  localparam logic [26:0] B_MARIN  = 27'(1) << 23;
  localparam logic [26:0] B_READ   = 27'(1) << 22;
  localparam logic [26:0] B_MDRIN  = 27'(1) << 21;
  localparam logic [26:0] B_MDROUT = 27'(1) << 20;
  localparam logic [26:0] B_IRIN   = 27'(1) << 19;
  localparam logic [26:0] B_RYIN   = 27'(1) << 18;
  localparam logic [26:0] B_RZIN   = 27'(1) << 17;
  localparam logic [26:0] B_ZLOW   = 27'(1) << 16;
  localparam logic [26:0] B_ZHIGH  = 27'(1) << 15;
  localparam logic [26:0] B_HIIN   = 27'(1) << 14;
  localparam logic [26:0] B_LOIN   = 27'(1) << 13;
  localparam logic [26:0] B_MUL    = 27'(1) << 10;
  localparam logic [26:0] B_AND    = 27'(1) << 4;
  localparam logic [26:0] B_NEGATE = 27'(1) << 2;
  localparam logic [26:0] B_RUN    = 27'(1);

  localparam logic [26:0] F_T0 = B_PCOUT | B_MARIN | B_INCPC | B_RZIN | B_RUN;
  localparam logic [26:0] F_T1 = B_ZLOW | B_PCIN | B_READ | B_MDRIN | B_RUN;
  localparam logic [26:0] F_T2 = B_MDROUT | B_IRIN | B_RUN;

  localparam logic [31:0] I_AND  = 32'h4A920000;
  localparam logic [31:0] I_MUL  = 32'h71180000;
  localparam logic [31:0] I_NEG  = 32'h80900000;
  localparam logic [31:0] I_NOP  = 32'hF8000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;

  typedef struct {
    logic [31:0] ir;
    logic        stop;
    logic [26:0] sig;
    logic [15:0] gin;
    logic [15:0] gout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] ir, input logic stop, input logic [26:0] s,
                     input logic [15:0] gin, input logic [15:0] gout);
    vec_t v;
    v.ir = ir; v.stop = stop; v.sig = s; v.gin = gin; v.gout = gout;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input logic [31:0] ir, input logic stop);
    add(ir, stop, F_T0, 16'h0, 16'h0);
    add(ir, stop, F_T1, 16'h0, 16'h0);
    add(ir, stop, F_T2, 16'h0, 16'h0);
  endtask

  task automatic check(input string name, input logic [26:0] es,
                       input logic [15:0] egin, input logic [15:0] egout);
    int bus;
    n_assert++;
    if ({sig, GPRin, GPRout} !== {es, egin, egout}) begin
      n_fail++;
      $display("FAIL %s: got sig=%07h GPRin=%04h GPRout=%04h, expected sig=%07h GPRin=%04h GPRout=%04h",
               name, sig, GPRin, GPRout, es, egin, egout);
    end
    bus = $countones({PCout, MDRout, Zlowout, Zhighout, |GPRout});
    n_assert++;
    if (bus > 1 || !$onehot0(GPRin) || !$onehot0(GPRout) || $countones(sig[12:1]) > 1) begin
      n_fail++;
      $display("FAIL %s_exclusive: bus drivers=%0d GPRin=%04h GPRout=%04h ops=%03h, required at most one each",
               name, bus, GPRin, GPRout, sig[12:1]);
    end
  endtask

  task automatic expect_cycle(input string name, input logic [26:0] es,
                              input logic [15:0] egin, input logic [15:0] egout);
    @(negedge Clock);
    check(name, es, egin, egout);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    Stop  = 1'b0;
    IRVal = I_AND;
    #1 check("reset_async_start", '0, 16'h0, 16'h0);
    repeat (2) @(negedge Clock);
    check("reset_held", '0, 16'h0, 16'h0);
    reset = 1'b0;
    check("idle_after_release", '0, 16'h0, 16'h0);

    // AND R5,R2,R4
    add_fetch(I_AND, 1'b0);
    add(I_AND, 1'b0, B_RYIN | B_RUN,          16'h0,    16'h0004);
    add(I_AND, 1'b0, B_AND | B_RZIN | B_RUN,  16'h0,    16'h0010);
    add(I_AND, 1'b0, B_ZLOW | B_RUN,          16'h0020, 16'h0);
    // MUL R2,R3
    add_fetch(I_MUL, 1'b0);
    add(I_MUL, 1'b0, B_RYIN | B_RUN,          16'h0, 16'h0004);
    add(I_MUL, 1'b0, B_MUL | B_RZIN | B_RUN,  16'h0, 16'h0008);
    add(I_MUL, 1'b0, B_ZLOW | B_LOIN | B_RUN, 16'h0, 16'h0);
    add(I_MUL, 1'b0, B_ZHIGH | B_HIIN | B_RUN,16'h0, 16'h0);
    // NEG R1,R2
    add_fetch(I_NEG, 1'b0);
    add(I_NEG, 1'b0, B_NEGATE | B_RZIN | B_RUN, 16'h0,    16'h0004);
    add(I_NEG, 1'b0, B_ZLOW | B_RUN,            16'h0002, 16'h0);
    // Unknown opcode 11111 acts as a NOP
    add_fetch(I_NOP, 1'b0);
    add(I_NOP, 1'b0, B_RUN, 16'h0, 16'h0);
    // AND with Stop raised in T4: completes, idles, resumes when Stop drops
    add_fetch(I_AND, 1'b0);
    add(I_AND, 1'b0, B_RYIN | B_RUN,          16'h0,    16'h0004);
    add(I_AND, 1'b1, B_AND | B_RZIN | B_RUN,  16'h0,    16'h0010);
    add(I_AND, 1'b1, B_ZLOW | B_RUN,          16'h0020, 16'h0);
    add(I_AND, 1'b1, '0,                      16'h0,    16'h0);
    add(I_AND, 1'b0, '0,                      16'h0,    16'h0);
    add(I_AND, 1'b0, F_T0,                    16'h0,    16'h0);

    foreach (vecs[i]) begin
      @(negedge Clock);
      IRVal = vecs[i].ir;
      Stop  = vecs[i].stop;
      check($sformatf("vec%0d", i), vecs[i].sig, vecs[i].gin, vecs[i].gout);
    end

    // Asynchronous reset while running, then HALT parks the sequencer
    @(negedge Clock);
    reset = 1'b1;
    #1 check("reset_async_t1", '0, 16'h0, 16'h0);
    @(negedge Clock);
    reset = 1'b0;
    IRVal = I_HALT;
    check("idle_before_halt", '0, 16'h0, 16'h0);
    expect_cycle("halt_t0", F_T0, 16'h0, 16'h0);
    expect_cycle("halt_t1", F_T1, 16'h0, 16'h0);
    expect_cycle("halt_t2", F_T2, 16'h0, 16'h0);
    expect_cycle("halt_t3", B_RUN, 16'h0, 16'h0);
    for (int k = 0; k < 20; k++)
      expect_cycle($sformatf("halted%0d", k), '0, 16'h0, 16'h0);

    reset = 1'b1;
    #1 check("reset_from_halted", '0, 16'h0, 16'h0);
    @(negedge Clock);
    reset = 1'b0;
    IRVal = I_AND;
    expect_cycle("t0_after_halt_reset", F_T0, 16'h0, 16'h0);
    expect_cycle("abort_t1", F_T1, 16'h0, 16'h0);
    expect_cycle("abort_t2", F_T2, 16'h0, 16'h0);
    expect_cycle("abort_t3", B_RYIN | B_RUN, 16'h0, 16'h0004);
    expect_cycle("abort_t4", B_AND | B_RZIN | B_RUN, 16'h0, 16'h0010);
    #2 reset = 1'b1;
    #1 check("reset_mid_t4", '0, 16'h0, 16'h0);
    @(negedge Clock);
    check("reset_mid_t4_held", '0, 16'h0, 16'h0);
    reset = 1'b0;
    expect_cycle("t0_after_abort", F_T0, 16'h0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port: Clock  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; one clock, no other clock domains.
REQ-003 SHALL have port: IRVal  input  32  instruction register contents from datapath.
REQ-004 SHALL have port: Stop  input  1  pause request, sampled at instruction boundaries.
REQ-005 SHALL have outputs, each 1 bit: PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, RYin, RZin, Zlowout, Zhighout, HIin, LOin, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, Run.
REQ-006 SHALL have outputs GPRin, GPRout  output  16  one-hot register strobes, matching datapath REGISTERS=16.
REQ-007 SHALL have parameters: BITS default 32, datapath width; REGISTERS default 16, GPR count.

Function
REQ-008 SHALL be a Moore FSM, one state per cycle; all outputs decoded from registered state plus latched IR fields, glitch-free.
REQ-009 States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED.
REQ-010 Fields: opcode=IRVal[31:27], ra=[26:23], rb=[22:19], rc=[18:15]; latched at the T2->T3 edge.
REQ-011 Fetch: T0 = PCout, MARin, IncPC, RZin; T1 = Zlowout, PCin, Read, MDRin; T2 = MDRout, IRin.
REQ-012 Opcodes (3-operand): 00011 ADD, 00100 SUB, 00101 SHR, 00110 SHL, 00111 ROR, 01000 ROL, 01001 AND, 01010 OR; T3 = GPRout[rb], RYin; T4 = GPRout[rc], op strobe, RZin; T5 = Zlowout, GPRin[ra]; done.
REQ-013 01110 MUL, 01111 DIV: T3 = GPRout[ra], RYin; T4 = GPRout[rb], op, RZin; T5 = Zlowout, LOin; T6 = Zhighout, HIin; done.
REQ-014 10000 NEG, 10001 NOT: T3 = GPRout[rb], op, RZin; T4 = Zlowout, GPRin[ra]; done.
REQ-015 11011 HALT: T3 -> HALTED; HALTED drives all strobes 0, exits only on reset.
REQ-016 Any other opcode: T3 asserts no strobes, then done (treated as NOP, 4 cycles total).
REQ-017 "Done": next state T0 if Stop=0, IDLE if Stop=1.
REQ-018 IDLE -> T0 when Stop=0; else remain IDLE.
REQ-019 Latency: ALU 6 cycles, MUL/DIV 7, NEG/NOT 5, NOP 4, T0 to T0.
REQ-020 At most one ALU op strobe, one GPRin bit, one GPRout bit, one bus driver (PCout/MDRout/Zlowout/Zhighout/GPRout) high in any cycle.
REQ-021 Run = 1 in T0..T6, 0 in IDLE and HALTED.
REQ-022 Stop asserted mid-instruction SHALL NOT truncate it; it takes effect at done.

Reset
REQ-023 reset high SHALL immediately force state IDLE, every output 0, latched fields 0, independent of Clock.
REQ-024 reset mid-instruction SHALL abandon it; no strobe asserted while reset high.
REQ-025 First rising edge after reset release with Stop=0 SHALL enter T0.

Structure
REQ-026 Shared package: opcode constants, state encoding, field bit positions, BITS/REGISTERS defaults.
REQ-027 One sub-module, ir_decode: combinational; IR -> opcode class (ALU3, MULDIV, UNARY, HALT, NOP) and one-hot 16-bit ra/rb/rc selects.

Verification
REQ-028 Reset, Stop=0, IRVal=32'h4A920000 (AND R5,R2,R4) -> T3 GPRout=0x0004+RYin; T4 GPRout=0x0010+AND+RZin; T5 Zlowout+GPRin=0x0020; T0 follows.
REQ-029 IRVal=32'h71180000 (MUL R2,R3) -> T3 GPRout[2]; T4 GPRout[3]+MUL; T5 LOin; T6 Zhighout+HIin; 7-cycle period.
REQ-030 IRVal=32'h80900000 (NEG R1,R2) -> T3 GPRout[2]+NEGATE+RZin; T4 GPRin[1]; 5-cycle period.
REQ-031 IRVal=32'hD8000000 (HALT) -> HALTED after T3, Run=0, all strobes 0 for 20 cycles; reset returns to IDLE.
REQ-032 Stop=1 raised in T4 of an AND -> T5 completes, then IDLE with Run=0; Stop=0 -> T0 next edge.
REQ-033 reset pulsed mid-T4 between edges -> outputs 0 immediately, state IDLE; opcode 11111 -> 4-cycle NOP, no GPRin.
